// File: rtl/vrf_wb_requester.sv
// vrf_wb_requester: FIFO-buffered VRF writeback requester; ports clk/reset, push_* in, req/en/we/addr/ref_out/ack handshake, full/count/overflow/starved status
module vrf_wb_requester #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16,
  parameter int ADDR_W       = 5,
  parameter int REF_W        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic                     push_we,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [REF_W-1:0]         push_ref,
  output logic                     full,
  input  logic                     flush,
  output logic                     req,
  input  logic                     ack,
  output logic                     en,
  output logic                     we,
  output logic [ADDR_W-1:0]        addr,
  output logic [REF_W-1:0]         ref_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     starved
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int EW = 1 + ADDR_W + REF_W;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] wait_q, wait_d;
  logic          overflow_q, overflow_d, starved_q, starved_d;
  logic          push, pop;
  logic [EW-1:0] head;
  assign full     = count_q == CW'(DEPTH);
  assign req      = count_q != '0;
  assign en       = req;
  assign head     = req ? mem_q[rd_ptr_q] : '0;
  assign {we, addr, ref_out} = head;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign starved  = starved_q;
  // flush swallows both the same-cycle push and the same-cycle grant
  always_comb begin
    push       = push_valid && !full && !flush;
    pop        = req && ack && !flush;
    wr_ptr_d   = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d   = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wait_d     = (flush || pop || !req) ? '0 :
                 (wait_q != SW'(STARVE_LIMIT)) ? wait_q + 1'b1 : wait_q;
    starved_d  = pop ? 1'b0 : (wait_d == SW'(STARVE_LIMIT)) ? 1'b1 : starved_q;
    overflow_d = overflow_q || (push_valid && full);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      overflow_q <= 1'b0;
      starved_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      overflow_q <= overflow_d;
      starved_q  <= starved_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {push_we, push_addr, push_ref};
  end
endmodule

// File: tb/tb_vrf_wb_requester.sv
// tb_vrf_wb_requester: directed and random checks of vrf_wb_requester against a queue model
module tb_vrf_wb_requester;
  localparam int DEPTH = 4;
  localparam int LIMIT = 16;
  localparam int AW    = 5;
  localparam int RW    = 4;
  logic          clk = 1'b0;
  logic          reset, push_valid, push_we, flush, ack;
  logic [AW-1:0] push_addr;
  logic [RW-1:0] push_ref;
  logic          full, req, en, we, overflow, starved;
  logic [AW-1:0] addr;
  logic [RW-1:0] ref_out;
  logic [2:0]    count;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [RW-1:0] rf;} ent_t;
  ent_t q[$];
  bit   m_ovf, m_stv;
  int   m_wait;
  int   checks = 0;
  int   failures = 0;
  vrf_wb_requester #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ADDR_W(AW), .REF_W(RW)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_we(push_we),
    .push_addr(push_addr), .push_ref(push_ref), .full(full), .flush(flush),
    .req(req), .ack(ack), .en(en), .we(we), .addr(addr), .ref_out(ref_out),
    .count(count), .overflow(overflow), .starved(starved)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit rst, input bit pv, input bit pwe, input logic [AW-1:0] pa,
                      input logic [RW-1:0] pr, input bit ak, input bit fl);
    bit   m_full, m_req, m_pop;
    ent_t h;
    reset = rst; push_valid = pv; push_we = pwe; push_addr = pa; push_ref = pr;
    ack = ak; flush = fl;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete(); m_ovf = 0; m_stv = 0; m_wait = 0;
    end else begin
      m_full = q.size() == DEPTH;
      m_req  = q.size() != 0;
      m_pop  = m_req && ak && !fl;
      if (pv && m_full) m_ovf = 1;
      if (fl || m_pop || !m_req) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
      if (m_pop) m_stv = 0;
      else if (m_wait == LIMIT) m_stv = 1;
      if (fl) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (pv && !m_full) q.push_back('{pwe, pa, pr});
      end
    end
    h = q.size() != 0 ? q[0] : '0;
    chk("req", 32'(req), 32'(q.size() != 0));
    chk("en", 32'(en), 32'(q.size() != 0));
    chk("we", 32'(we), 32'(h.we));
    chk("addr", 32'(addr), 32'(h.addr));
    chk("ref", 32'(ref_out), 32'(h.rf));
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("starved", 32'(starved), 32'(m_stv));
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1'($urandom), 0);
    chk("idle_count", 32'(count), 0);
    step(0, 1, 1, 5, 2, 1, 0);
    chk("t2_addr", 32'(addr), 5);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t2_empty", 32'(count), 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 0, AW'(i), RW'(i), 0, 0);
    chk("t3_full", 32'(full), 1);
    step(0, 1, 1, 9, 0, 0, 0);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_cnt", 32'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_order", 32'(addr), i);
      step(0, 0, 0, 0, 0, 1, 0);
    end
    chk("t3_drained", 32'(req), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 20, 1, 0, 0);
    step(0, 1, 0, 21, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", 32'(addr), 20 + i);
      step(0, 1, 1, AW'(22 + i), RW'(i), 1, 0);
      chk("t4_cnt", 32'(count), 2);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 3, 0, 0);
    for (int i = 0; i < LIMIT - 1; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("t5_not_yet", 32'(starved), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t5_starved", 32'(starved), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t5_cleared", 32'(starved), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, AW'(i), 0, 0, 0);
    step(0, 1, 1, 30, 0, 1, 1);
    chk("t6_cnt", 32'(count), 0);
    chk("t6_req", 32'(req), 0);
    step(0, 1, 1, 7, 5, 0, 0);
    chk("t6_first", 32'(addr), 7);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 1'($urandom),
           AW'($urandom), RW'($urandom), $urandom_range(0, 9) < (i % 400 < 100 ? 1 : 5),
           $urandom_range(0, 49) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
